block_rev_ctrl: RTL and testbench

BLOCK_REV_CTRL -- requirements
Module: block_rev_ctrl

---
 rtl/block_rev_ctrl_pkg.sv | 12 +
 rtl/block_rev_ctrl_if.sv | 35 +++
 rtl/block_rev_ctrl_byte_rev64.sv | 19 +
 rtl/block_rev_ctrl.sv | 133 +++++++++++++
 tb/tb_block_rev_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/block_rev_ctrl_pkg.sv
// rtl/block_rev_ctrl_pkg.sv - shared types and constants for the block reverser
package block_rev_ctrl_pkg;

  localparam int WORD_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/block_rev_ctrl_if.sv
// rtl/block_rev_ctrl_if.sv - input/output word streams of the block reverser
interface block_rev_ctrl_if;
  import block_rev_ctrl_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic              out_last;

  // Producer/consumer side (testbench or upstream/downstream logic)
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_last
  );

  // Block reverser side
  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_last
  );

endinterface

// File: rtl/block_rev_ctrl_byte_rev64.sv
// rtl/block_rev_ctrl_byte_rev64.sv - combinational byte-order reversal of one word
module byte_rev64
  import block_rev_ctrl_pkg::*;
(
  input  logic [WORD_W-1:0] data_i,
  output logic [WORD_W-1:0] data_o
);

  localparam int NB = WORD_W / 8;

  // Byte i moves to byte NB-1-i; bit order inside each byte is kept
  always_comb begin
    data_o = '0;
    for (int i = 0; i < NB; i++) begin
      data_o[8*i +: 8] = data_i[8*(NB-1-i) +: 8];
    end
  end

endmodule

// File: rtl/block_rev_ctrl.sv
// rtl/block_rev_ctrl.sv - buffers a block of words and replays it reversed, byte-swapped
module block_rev_ctrl
  import block_rev_ctrl_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [$clog2(DEPTH):0] len,
  block_rev_ctrl_if.slave        bus,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  state_e            state_q, state_d;
  logic [LW-1:0]     len_q, len_d;
  logic [LW-1:0]     wr_cnt_q, wr_cnt_d;
  logic [AW-1:0]     rd_idx_q, rd_idx_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [WORD_W-1:0] buf_q [DEPTH];

  logic [LW-1:0]     len_m1;
  logic              len_ok;
  logic              wr_en;
  logic [WORD_W-1:0] rd_word;
  logic [WORD_W-1:0] rev_word;

  logic              in_ready_c;
  logic              out_valid_c;
  logic              out_last_c;

  assign len_m1 = len_q - LW'(1);
  assign len_ok = (len != '0) && (len <= LW'(DEPTH));
  assign wr_en  = (state_q == FILL) && bus.in_valid;

  // State and counter registers; buffer contents are deliberately left out of reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      len_q    <= '0;
      wr_cnt_q <= '0;
      rd_idx_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      wr_cnt_q <= wr_cnt_d;
      rd_idx_q <= rd_idx_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Next state: capture on start, count words in, walk the buffer backwards out
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    wr_cnt_d = wr_cnt_q;
    rd_idx_d = rd_idx_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len_ok) begin
            len_d    = len;
            wr_cnt_d = '0;
            state_d  = FILL;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      FILL: begin
        if (bus.in_valid) begin
          wr_cnt_d = wr_cnt_q + LW'(1);
          if (wr_cnt_q == len_m1) begin
            state_d  = DRAIN;
            rd_idx_d = len_m1[AW-1:0];
          end
        end
      end
      DRAIN: begin
        if (bus.out_ready) begin
          if (rd_idx_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            rd_idx_d = rd_idx_q - AW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Word buffer write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf_q[wr_cnt_q[AW-1:0]] <= bus.in_data;
    end
  end

  assign rd_word = buf_q[rd_idx_q];

  byte_rev64 u_byte_rev (
    .data_i (rd_word),
    .data_o (rev_word)
  );

  // Handshake and status outputs decoded from the current state
  always_comb begin
    in_ready_c  = (state_q == FILL);
    out_valid_c = (state_q == DRAIN);
    out_last_c  = (state_q == DRAIN) && (rd_idx_q == '0);
    busy        = (state_q != IDLE);
    done        = done_q;
    err         = err_q;
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_last  = out_last_c;
  assign bus.out_data  = rev_word;

endmodule

// File: tb/tb_block_rev_ctrl.sv
// tb/tb_block_rev_ctrl.sv - scoreboard bench for block_rev_ctrl
module tb_block_rev_ctrl;
  import block_rev_ctrl_pkg::*;

  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] len;
  logic          busy, done, err;

  block_rev_ctrl_if bus();

  block_rev_ctrl #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .len   (len),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [63:0] blk [16];
  int          rmode = 0;
  bit          err_allowed = 1'b0;

  function automatic logic [63:0] brev(input logic [63:0] x);
    logic [63:0] r;
    r = {<<8{x}};
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [63:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    sb.push_back(e);
  endtask

  task automatic push_model(input int n);
    for (int k = 0; k < n; k++) push_exp(brev(blk[n-1-k]), k == n - 1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    if (busy) begin
      checks++; errors++;
      $display("FAIL wait_idle: busy still %0d after %0d cycles", busy, t);
    end
  endtask

  task automatic send_block(input int n, input bit gaps, input bit b2b, input int abort_after);
    int  t;
    int  sent;
    bit  acc;
    t = 0;
    if (b2b) begin
      while (!done && t < 2000) begin
        @(posedge clk); #1;
        t++;
      end
      if (!done) begin
        checks++; errors++;
        $display("FAIL b2b_wait: done=%0d, expected 1 within budget", done);
      end
    end else begin
      wait_idle();
    end
    start        = 1'b1;
    len          = LW'(n);
    bus.in_valid = 1'b1;
    bus.in_data  = 64'hDEAD_BEEF_BAD0_0BAD;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_busy", busy, 1);
    sent = 0;
    t    = 0;
    while (sent < n && t < 2000) begin
      if (abort_after >= 0 && sent == abort_after) break;
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
        start        = $urandom_range(0, 1) == 1;
        len          = '0;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = blk[sent];
      end
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (acc) sent++;
      t++;
    end
    bus.in_valid = 1'b0;
    if (abort_after < 0 && sent != n) begin
      checks++; errors++;
      $display("FAIL fill_timeout: accepted %0d words, required %0d", sent, n);
    end
  endtask

  task automatic err_case(input logic [LW-1:0] l);
    wait_idle();
    err_allowed = 1'b1;
    start = 1'b1;
    len   = l;
    @(posedge clk); #1;
    start = 1'b0;
    chk("err_pulse", err, 1);
    chk("err_busy", busy, 0);
    chk("err_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    chk("err_clear", err, 0);
    chk("err_busy2", busy, 0);
    chk("err_in_ready2", bus.in_ready, 0);
    err_allowed = 1'b0;
  endtask

  // Consumer: always ready, random ready, or three stall cycles per word
  int stall_cnt = 0;
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = $urandom_range(0, 1) == 1;
        default: begin
          if (bus.out_valid && stall_cnt < 3) begin
            bus.out_ready = 1'b0;
            stall_cnt++;
          end else if (bus.out_valid) begin
            bus.out_ready = 1'b1;
            stall_cnt = 0;
          end else begin
            bus.out_ready = 1'b0;
          end
        end
      endcase
    end
  end

  // Monitor: pops the scoreboard on every accepted output word
  initial begin
    bit          pend_done;
    bit          prev_stall;
    logic [63:0] prev_data;
    logic        prev_last;
    exp_t        e;
    pend_done  = 1'b0;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend_done  = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", bus.out_valid, 1);
          chk("stall_data", bus.out_data, prev_data);
          chk("stall_last", bus.out_last, prev_last);
        end
        if (pend_done || done) chk("done_pulse", done, pend_done);
        if (err && !err_allowed) chk("unexpected_err", err, 0);
        pend_done = 1'b0;
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL out_unexpected: got %h with no word expected", bus.out_data);
          end else begin
            e = sb.pop_front();
            chk("out_data", bus.out_data, e.data);
            chk("out_last", bus.out_last, e.last);
            pend_done = e.last;
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
        prev_last  = bus.out_last;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst          = 1'b1;
    start        = 1'b0;
    len          = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;

    // Single word block
    rmode  = 0;
    blk[0] = 64'h0011223344556677;
    push_exp(64'h7766554433221100, 1'b1);
    send_block(1, 1'b0, 1'b0, -1);

    // Two word block
    blk[0] = 64'h0001020304050607;
    blk[1] = 64'h08090A0B0C0D0E0F;
    push_exp(64'h0F0E0D0C0B0A0908, 1'b0);
    push_exp(64'h0706050403020100, 1'b1);
    send_block(2, 1'b0, 1'b0, -1);

    // Illegal lengths
    err_case('0);
    err_case(LW'(DEPTH + 1));

    // Full block with input gaps and output stalls
    rmode = 2;
    for (int i = 0; i < 8; i++) blk[i] = {$urandom, $urandom};
    push_model(8);
    send_block(8, 1'b1, 1'b0, -1);
    wait_idle();

    // Reset in the middle of filling
    rmode = 0;
    for (int i = 0; i < 5; i++) blk[i] = {$urandom, $urandom};
    send_block(5, 1'b0, 1'b0, 3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", bus.in_ready, 0);
    chk("abort_out_valid", bus.out_valid, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("abort_idle", busy, 0);
    blk[0] = {$urandom, $urandom};
    push_model(1);
    send_block(1, 1'b0, 1'b0, -1);

    // Back-to-back blocks started in the done cycle
    rmode = 1;
    for (int i = 0; i < 3; i++) blk[i] = {$urandom, $urandom};
    push_model(3);
    send_block(3, 1'b0, 1'b0, -1);
    for (int i = 0; i < 4; i++) blk[i] = {$urandom, $urandom};
    push_model(4);
    send_block(4, 1'b0, 1'b1, -1);

    // Random blocks
    for (int r = 0; r < 8; r++) begin
      rmode = $urandom_range(0, 2);
      n     = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) blk[i] = {$urandom, $urandom};
      push_model(n);
      send_block(n, $urandom_range(0, 1) == 1, (r % 3) == 2, -1);
    end

    wait_idle();
    repeat (5) @(posedge clk);
    #1;
    chk("sb_empty", 64'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
